// File: rtl/tick_divider_prog_if.sv
// Control/status bundle for tick_divider_prog: the master drives the controls,
// the slave (the divider) returns count, modulus state and the tick.
interface tick_divider_prog_if #(
  parameter int N = 16
);
  logic         en;
  logic         clr;
  logic         mode;
  logic         start;
  logic         mod_wr;
  logic [N-1:0] mod_in;
  logic [N-1:0] count;
  logic [N-1:0] mod_active;
  logic         mod_pending;
  logic         busy;
  logic         max_tick;

  modport master (
    output en, clr, mode, start, mod_wr, mod_in,
    input  count, mod_active, mod_pending, busy, max_tick
  );

  modport slave (
    input  en, clr, mode, start, mod_wr, mod_in,
    output count, mod_active, mod_pending, busy, max_tick
  );
endinterface

// File: rtl/tick_divider_prog.sv
// Runtime-programmable mod-M tick generator with periodic and one-shot modes.
// A new modulus is staged in a shadow register and only takes effect at a wrap.
module tick_divider_prog #(
  parameter int N         = 16,
  parameter int M_DEFAULT = 10
) (
  input  logic               clk,
  input  logic               reset,
  tick_divider_prog_if.slave bus
);

  localparam logic [N-1:0] ZERO    = '0;
  localparam logic [N-1:0] ONE     = N'(1);
  localparam logic [N-1:0] M_RESET = N'(M_DEFAULT);

  // Handshake: mod_wr is a single-cycle strobe with no back-pressure; a write
  // with mod_in==0 is dropped, any other value always lands in the shadow.

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t       state;
  state_t       state_nxt;

  logic         busy_reg;
  logic         run;
  logic         idle;
  logic         at_last;
  logic         term;
  logic         tick;
  logic         apply;
  logic         wr_ok;

  logic [N-1:0] count_r;
  logic [N-1:0] mod_active_r;
  logic [N-1:0] shadow_r;
  logic         pending_r;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. Periodic mode keeps the block armed so that a switch to
  // one-shot lets the period in flight finish and tick once before idling.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (bus.clr) begin
      state_nxt = ST_IDLE;
    end else if (!bus.mode) begin
      state_nxt = ST_RUN;
    end else if (state == ST_RUN) begin
      if (term) begin
        state_nxt = ST_IDLE;
      end
    end else if (bus.start) begin
      state_nxt = ST_RUN;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_reg = (state == ST_RUN);
    run      = !bus.mode || busy_reg;
    idle     = bus.mode && !busy_reg;
  end

  // ---------------------------------------------------------------------------
  // Terminal detection and modulus handling
  // ---------------------------------------------------------------------------
  always_comb begin
    at_last = (count_r == (mod_active_r - ONE));
    term    = run && bus.en && at_last;
    tick    = term && !bus.clr;
    apply   = pending_r && (term || bus.clr || idle);
    wr_ok   = bus.mod_wr && (bus.mod_in != ZERO);
  end

  // ---------------------------------------------------------------------------
  // Counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= ZERO;
    end else if (bus.clr) begin
      count_r <= ZERO;
    end else if (run && bus.en) begin
      if (term) begin
        count_r <= ZERO;
      end else begin
        count_r <= count_r + ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Active modulus: swapped only at an apply point, so count is always 0 or
  // freshly cleared when it changes and never exceeds mod_active-1.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mod_active_r <= M_RESET;
    end else if (apply) begin
      mod_active_r <= shadow_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow and pending flag; a write coinciding with an apply stays pending
  // for the next apply point.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_r <= M_RESET;
    end else if (wr_ok) begin
      shadow_r <= bus.mod_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r <= 1'b0;
    end else if (wr_ok) begin
      pending_r <= 1'b1;
    end else if (apply) begin
      pending_r <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.count       = count_r;
  assign bus.mod_active  = mod_active_r;
  assign bus.mod_pending = pending_r;
  assign bus.busy        = run;
  assign bus.max_tick    = tick;

endmodule

// File: tb/tb_tick_divider_prog.sv
// Bench for tick_divider_prog: directed scenarios plus randomized traffic,
// all checked cycle by cycle against an arithmetic reference model.
module tb_tick_divider_prog;

  localparam int N = 16;
  localparam int M_DEF = 10;

  logic clk;
  logic reset;

  tick_divider_prog_if #(.N(N)) bus ();

  tick_divider_prog #(.N(N), .M_DEFAULT(M_DEF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [N-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (plain integers)
  // ---------------------------------------------------------------------------
  int m_count, m_mod, m_shadow;
  bit m_pend, m_armed;

  task automatic model_reset();
    m_count  = 0;
    m_mod    = M_DEF;
    m_shadow = M_DEF;
    m_pend   = 0;
    m_armed  = 0;
  endtask

  // Observed DUT values from the most recent step
  logic         obs_tick;
  logic         obs_busy;
  logic [N-1:0] obs_count;
  logic [N-1:0] obs_mod;
  int           cycle;

  task automatic step(input bit i_en, input bit i_clr, input bit i_mode,
                      input bit i_start, input bit i_wr, input int i_in);
    bit running, e_tick, do_apply;
    @(negedge clk);
    bus.en     = i_en;
    bus.clr    = i_clr;
    bus.mode   = i_mode;
    bus.start  = i_start;
    bus.mod_wr = i_wr;
    bus.mod_in = N'(i_in);
    #1;
    running = !i_mode || m_armed;
    e_tick  = running && i_en && !i_clr && (m_count == m_mod - 1);
    exp_q.push_back(N'(m_count));
    obs_tick  = bus.max_tick;
    obs_busy  = bus.busy;
    obs_count = bus.count;
    obs_mod   = bus.mod_active;
    check("count",       32'(bus.count),       32'(exp_q.pop_front()));
    check("mod_active",  32'(bus.mod_active),  32'(m_mod));
    check("mod_pending", 32'(bus.mod_pending), 32'(m_pend));
    check("busy",        32'(bus.busy),        32'(running));
    check("max_tick",    32'(bus.max_tick),    32'(e_tick));
    // Advance the model across the coming edge
    do_apply = m_pend && (e_tick || i_clr || (i_mode && !m_armed));
    if (i_clr) begin
      m_count = 0;
      m_armed = 0;
    end else begin
      if (running && i_en) m_count = (m_count + 1) % m_mod;
      if (!i_mode)      m_armed = 1;
      else if (m_armed) m_armed = !e_tick;
      else              m_armed = i_start;
    end
    if (do_apply) begin
      m_mod  = m_shadow;
      m_pend = 0;
    end
    if (i_wr && i_in != 0) begin
      m_shadow = i_in;
      m_pend   = 1;
    end
    cycle++;
  endtask

  task automatic drive_idle();
    bus.en = 0; bus.clr = 0; bus.mode = 0; bus.start = 0;
    bus.mod_wr = 0; bus.mod_in = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cycle = 0;
  endtask

  task automatic run_until_count(input bit i_mode, input int target);
    int guard = 0;
    while (m_count != target && guard < 100) begin
      step(1, 0, i_mode, 0, 0, 0);
      guard++;
    end
    check("wait_count", 32'(m_count), 32'(target));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int first_tick, n_ticks;
    bit r_mode;
    reset = 1'b1;
    drive_idle();
    do_reset();

    // Defaults: ticks at cycles 9, 19, 29
    first_tick = -1;
    n_ticks = 0;
    for (int i = 0; i < 30; i++) begin
      step(1, 0, 0, 0, 0, 0);
      if (obs_tick) begin
        n_ticks++;
        if (first_tick < 0) first_tick = i;
      end
    end
    check("first_tick_cycle", 32'(first_tick), 32'd9);
    check("ticks_in_30", 32'(n_ticks), 32'd3);

    // Stage modulus 4 at count 3, then a zero write that must be ignored
    run_until_count(0, 3);
    step(1, 0, 0, 0, 1, 4);
    step(1, 0, 0, 0, 1, 0);
    run_until_count(0, 9);
    step(1, 0, 0, 0, 0, 0);
    check("tick_old_mod", 32'(obs_tick), 32'd1);
    step(1, 0, 0, 0, 0, 0);
    check("mod_after_wrap", 32'(obs_mod), 32'd4);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0, 0);

    // Enable gap at count 6 under a modulus of 10
    step(1, 0, 0, 0, 1, 10);
    step(1, 1, 0, 0, 0, 0);
    run_until_count(0, 6);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
    check("hold_count", 32'(obs_count), 32'd6);
    run_until_count(0, 0);

    // One-shot with modulus 3
    step(1, 0, 0, 0, 1, 3);
    begin
      int guard = 0;
      step(1, 0, 1, 0, 0, 0);
      while (m_armed && guard < 50) begin
        step(1, 0, 1, 0, 0, 0);
        guard++;
      end
    end
    step(1, 0, 1, 0, 0, 0);
    check("oneshot_idle", 32'(obs_busy), 32'd0);
    check("oneshot_mod", 32'(obs_mod), 32'd3);
    step(1, 0, 1, 1, 0, 0);
    n_ticks = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 1, (i == 1), 0, 0);
      if (obs_tick) n_ticks++;
    end
    check("oneshot_ticks", 32'(n_ticks), 32'd1);
    check("oneshot_end_count", 32'(obs_count), 32'd0);

    // clr applies a pending modulus and suppresses the tick
    step(1, 0, 0, 0, 1, 10);
    step(1, 1, 0, 0, 0, 0);
    run_until_count(0, 6);
    step(1, 0, 0, 0, 1, 5);
    step(1, 1, 0, 0, 0, 0);
    check("clr_no_tick", 32'(obs_tick), 32'd0);
    step(1, 0, 0, 0, 0, 0);
    check("clr_count", 32'(obs_count), 32'd0);
    check("clr_mod", 32'(obs_mod), 32'd5);
    step(1, 1, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    check("clr_start_idle", 32'(obs_busy), 32'd0);

    // Modulus 1: continuous tick, then async reset mid-cycle
    step(1, 0, 0, 0, 1, 1);
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 0, 0);
      check("mod1_tick", 32'(obs_tick), 32'd1);
    end
    step(1, 0, 0, 0, 1, 7);
    #1;
    reset = 1'b1;
    #1;
    check("rst_count",   32'(bus.count),       32'd0);
    check("rst_mod",     32'(bus.mod_active),  32'(M_DEF));
    check("rst_pending", 32'(bus.mod_pending), 32'd0);
    check("rst_busy",    32'(bus.busy),        32'd1);
    check("rst_tick",    32'(bus.max_tick),    32'd0);
    do_reset();

    // Randomized traffic
    r_mode = 0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 49) == 0) r_mode = !r_mode;
      step($urandom_range(0, 9) < 8,
           $urandom_range(0, 39) == 0,
           r_mode,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 19) == 0,
           int'($urandom_range(0, 12)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tick_divider_prog.md
Name: tick_divider_prog

Overview:
Runtime-programmable mod-M tick generator. It replaces fixed-modulus counters in the timing paths (pixel/frame pacing, game-logic timers, animation rates). It adds:
- count enable and synchronous clear
- a glitch-free modulus change, applied only at a wrap
- a one-shot mode for single timed delays

Outputs are a single-cycle max_tick plus the live count.

Parameters:
- N, 16: counter and modulus width in bits.
- M_DEFAULT, 10: modulus after reset; legal range 1..2^N-1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  count enable; the counter advances only when en=1
- clr  in  1  synchronous restart (see Behaviour)
- mode  in  1  0 = periodic, 1 = one-shot
- start  in  1  one-shot trigger pulse; ignored when mode=0
- mod_wr  in  1  modulus write strobe
- mod_in  in  N  requested modulus
- count  out  N  current count value
- mod_active  out  N  modulus currently in use
- mod_pending  out  1  a new modulus is staged and not yet applied
- busy  out  1  counter is running
- max_tick  out  1  terminal-count pulse

Behaviour:
- Reset (async) values: count=0, mod_active=M_DEFAULT, shadow=M_DEFAULT, mod_pending=0, busy_reg=0.
- Running condition: run = (mode==0) | busy_reg. busy = run.
- Terminal condition: term = run & en & (count == mod_active-1).
- max_tick = term.
  - Combinational from registers plus en.
  - At most one cycle per period.
  - Never asserted while idle or en=0.
- Counting, in a cycle with run & en & !clr:
  - If term: count <= 0.
  - Otherwise: count <= count+1.
  - With en=0 or !run: count holds.
- Period: with en held high in periodic mode, max_tick fires every mod_active cycles. The first tick after reset is in cycle M_DEFAULT-1 (count values 0..M-1).
- mod_active=1: term is true every enabled cycle, so max_tick is continuous while en=1 and count stays 0.
- Modulus write:
  - mod_wr with mod_in!=0: shadow <= mod_in, mod_pending <= 1.
  - mod_wr with mod_in==0: ignored; shadow and pending are unchanged.
  - Back-to-back writes: the last write wins.
- Modulus apply:
  - Applied when mod_pending=1 and any of the following occurs: term, clr, or the block is idle (mode=1 & busy_reg=0).
  - Effect: mod_active <= shadow, mod_pending <= 0.
  - The value applied is the shadow as of the start of that cycle.
  - A mod_wr in the same cycle as an apply loads the shadow and leaves mod_pending=1 for the next apply point.
- A period in progress always completes with the old modulus; no short or long glitch periods occur.
- One-shot mode (mode=1):
  - Idle state: busy_reg=0, count=0.
  - start=1 while idle: busy_reg <= 1; counting begins the next cycle.
  - On term: count <= 0 and busy_reg <= 0, so exactly one max_tick is produced per start.
  - start while busy_reg=1 is ignored (no retrigger).
  - start and term in the same cycle: term wins, the block goes idle and start is dropped.
- Mode changes mid-run:
  - mode 0→1 while counting: busy_reg <= 1 on the same edge, so the current period finishes, ticks once, then the block idles.
  - mode 1→0: the block runs immediately from the current count.
- clr has priority over en, start and term. It sets count <= 0 and busy_reg <= 0, applies a pending modulus, and suppresses max_tick that cycle.
- Reset asserted mid-operation: all state returns to the reset values immediately, including a staged modulus, which is lost.
- Arithmetic: unsigned N-bit. count never exceeds mod_active-1, because a modulus change applies only when count returns to 0.

Test Plan:
1. Reset, en=1, mode=0, defaults → max_tick high at cycles 9, 19, 29 after reset release; count sequence 0..9 repeating; busy=1.
2. Write mod_in=4 when count=3 → mod_pending=1 and ticks continue at the count=9 spacing until the next wrap; then mod_active=4 and ticks arrive every 4 cycles. Write mod_in=0 → ignored.
3. Toggle en low for 5 cycles at count=6 → count holds at 6, no max_tick; the period stretches to 15 cycles.
4. mode=1, mod_active=3, start pulse → busy=1; one max_tick at the third counting cycle, then busy=0 and count=0. A second start while busy produces no extra tick.
5. Assert clr at count=7 with mod_in=5 pending → count=0, mod_active=5, no tick that cycle. Assert clr and start together → stays idle.
6. mod_active=1, en=1 → max_tick constant high; async reset asserted mid-run → all outputs return to reset values without a clock edge.
